// File: rtl/seq_mul4_ctrl.sv
// Shift-and-add 4x4 -> 8-bit unsigned multiplier sequencer over a shared ripple adder.
// Optional build macro SEQ_MUL4_EARLY_EXIT_EN: finish as soon as no multiplier bits remain.
//
// state | meaning
// IDLE  | waiting for start; operands latched on accept
// RUN   | one multiplier bit consumed per clock
// DONE  | one-cycle done pulse, product valid
module seq_mul4_ctrl #(
  parameter int WIDTH = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] product
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t state, state_nxt;

  logic [WIDTH-1:0]   m_q, m_nxt;
  logic [WIDTH-1:0]   acc_q, acc_nxt;
  logic [WIDTH-1:0]   q_q, q_nxt;
  logic [2:0]         cnt_q, cnt_nxt;
  logic [2*WIDTH-1:0] product_nxt;

  logic [WIDTH-1:0] add_a, add_b, add_sum;
  logic             add_cin, add_sub, add_cout;

  logic [WIDTH-1:0]   acc_sh, q_sh;
  logic [2:0]         cnt_inc;
  logic               run_exit;
  logic [2*WIDTH-1:0] prod_final;

  // Adder operands: add mode only, carry-in tied low.
  assign add_a   = acc_q;
  assign add_b   = q_q[0] ? m_q : '0;
  assign add_cin = 1'b0;
  assign add_sub = 1'b0;

  always_comb begin
    logic             cy;
    logic [WIDTH-1:0] bx;
    add_sum = '0;
    bx      = add_b ^ {WIDTH{add_sub}};
    cy      = add_cin;
    for (int i = 0; i < WIDTH; i++) begin
      add_sum[i] = add_a[i] ^ bx[i] ^ cy;
      cy         = (add_a[i] & bx[i]) | (cy & (add_a[i] ^ bx[i]));
    end
    add_cout = cy;
  end

  // The carry C lives only for the cycle: shifting {C,ACC,Q} right moves it into ACC's MSB
  // and leaves C zero, so it never needs its own flop.
  assign acc_sh  = {add_cout, add_sum[WIDTH-1:1]};
  assign q_sh    = {add_sum[0], q_q[WIDTH-1:1]};
  assign cnt_inc = cnt_q + 3'd1;

  always_comb begin
`ifdef SEQ_MUL4_EARLY_EXIT_EN
    run_exit   = (cnt_inc == 3'd4) || ((q_sh & (4'hF >> cnt_inc)) == 4'h0);
    prod_final = {acc_sh, q_sh} >> (3'd4 - cnt_inc);
`else
    run_exit   = (cnt_inc == 3'd4);
    prod_final = {acc_sh, q_sh};
`endif
  end

  always_comb begin
    state_nxt   = state;
    m_nxt       = m_q;
    acc_nxt     = acc_q;
    q_nxt       = q_q;
    cnt_nxt     = cnt_q;
    product_nxt = product;
    busy        = (state != IDLE);
    done        = (state == DONE);
    case (state)
      IDLE: begin
        if (start) begin
          m_nxt     = a;
          q_nxt     = b;
          acc_nxt   = '0;
          cnt_nxt   = '0;
          state_nxt = RUN;
        end
      end
      RUN: begin
        acc_nxt = acc_sh;
        q_nxt   = q_sh;
        cnt_nxt = cnt_inc;
        if (run_exit) begin
          product_nxt = prod_final;
          state_nxt   = DONE;
        end
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      m_q     <= '0;
      acc_q   <= '0;
      q_q     <= '0;
      cnt_q   <= '0;
      product <= '0;
    end else begin
      state   <= state_nxt;
      m_q     <= m_nxt;
      acc_q   <= acc_nxt;
      q_q     <= q_nxt;
      cnt_q   <= cnt_nxt;
      product <= product_nxt;
    end
  end

endmodule

// File: tb/tb_seq_mul4_ctrl.sv
// Directed bench for seq_mul4_ctrl: latency, done pulse, retrigger, reset abort, full sweep.
module tb_seq_mul4_ctrl;

  logic       clk, rst, start;
  logic [3:0] a, b;
  logic       busy, done;
  logic [7:0] product;

  int tests = 0;
  int fails = 0;

  seq_mul4_ctrl #(.WIDTH(4)) dut (
    .clk(clk), .rst(rst), .start(start), .a(a), .b(b),
    .busy(busy), .done(done), .product(product)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Expected done cycle relative to the start cycle.
  function automatic int lat(input logic [3:0] bv);
`ifdef SEQ_MUL4_EARLY_EXIT_EN
    int n;
    if (bv[3])      n = 4;
    else if (bv[2]) n = 3;
    else if (bv[1]) n = 2;
    else            n = 1;
    return n + 1;
`else
    return 5;
`endif
  endfunction

  // Start in the current cycle, then watch a fixed 12-cycle window.
  task automatic do_op(input logic [3:0] ai, input logic [3:0] bi, input logic [7:0] exp);
    int         l, dcyc, pulses, busy_bad;
    logic [7:0] pcap;
    string      id;
    id       = $sformatf("%0d*%0d", ai, bi);
    l        = lat(bi);
    dcyc     = -1;
    pulses   = 0;
    busy_bad = 0;
    pcap     = 'x;
    a = ai; b = bi; start = 1'b1;
    check({id, " busy_c0"}, busy, 0);
    step();
    start = 1'b0;
    a = 4'($urandom);
    b = 4'($urandom);
    for (int c = 1; c <= 12; c++) begin
      if (busy !== (c <= l)) busy_bad++;
      if (done === 1'b1) begin
        pulses++;
        if (dcyc < 0) begin
          dcyc = c;
          pcap = product;
        end
      end
      step();
    end
    check({id, " product_at_done"}, pcap, exp);
    check({id, " done_cycle"}, dcyc, l);
    check({id, " done_pulses"}, pulses, 1);
    check({id, " busy_window_errors"}, busy_bad, 0);
    check({id, " product_hold"}, product, exp);
  endtask

  initial begin
    int         l, pulses;
    logic [7:0] pcap;
    rst = 1'b1; start = 1'b0; a = '0; b = '0;
    step();
    step();
    rst = 1'b0;
    check("reset busy", busy, 0);
    check("reset done", done, 0);
    check("reset product", product, 8'h00);
    step();

    do_op(4'd15, 4'd15, 8'hE1);
    do_op(4'd9,  4'd6,  8'h36);
    do_op(4'd7,  4'd0,  8'h00);
    do_op(4'd0,  4'd11, 8'h00);

    // Requests while busy are dropped; first IDLE cycle accepts a new one.
    l = lat(4'd5);
    pulses = 0;
    pcap = 'x;
    a = 4'd3; b = 4'd5; start = 1'b1;
    step();
    start = 1'b0;
    for (int c = 1; c <= l; c++) begin
      if (c >= 2) begin
        start = 1'b1; a = 4'd15; b = 4'd15;
      end
      if (done === 1'b1) begin
        pulses++;
        pcap = product;
      end
      step();
    end
    check("retrigger done_pulses", pulses, 1);
    check("retrigger product", pcap, 8'h0F);
    check("retrigger done_after", done, 0);
    do_op(4'd15, 4'd15, 8'hE1);

    // Reset mid-RUN aborts with no done pulse.
    a = 4'd12; b = 4'd13; start = 1'b1;
    step();
    start = 1'b0;
    step();
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("abort busy_c4", busy, 0);
    check("abort done_c4", done, 0);
    check("abort product_c4", product, 8'h00);
    step();
    check("abort done_c5", done, 0);
    check("abort busy_c5", busy, 0);
    do_op(4'd12, 4'd13, 8'h9C);

    for (int i = 0; i < 256; i++) begin
      logic [3:0] ai, bi;
      logic [7:0] ev;
      ai = 4'(i >> 4);
      bi = 4'(i);
      ev = 8'(ai * bi);
      do_op(ai, bi, ev);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/seq_mul4_ctrl.md
# seq_mul4_ctrl

Sequencing controller that time-shares one 4-bit ripple adder/subtractor to perform an unsigned 4×4 → 8-bit shift-and-add multiply. Operands are latched on a start request and one multiplier bit is processed per clock. The result is returned with a one-cycle done pulse. It sits above the combinational adder datapath and is the only driver of that adder's operand and carry-in inputs.

## Interface
Parameters:
- WIDTH, 4, operand width; fixed at 4 for this revision, no other value supported.

Ports (one clock; reset is synchronous and active-high):
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- start  input  1  request. Sampled only in IDLE.
- a  input  4  multiplicand, unsigned. Latched when start is accepted.
- b  input  4  multiplier, unsigned. Latched when start is accepted.
- busy  output  1  high whenever state ≠ IDLE.
- done  output  1  one-cycle pulse; product valid in the same cycle.
- product  output  8  registered result. Holds until the next completion or reset.

## Operation
- Internal registers:
  - M[3:0]: latched multiplicand.
  - ACC[3:0] plus carry C: upper partial product.
  - Q[3:0]: multiplier, shifted right each step.
  - CNT[2:0]: iteration counter.
  - state ∈ {IDLE, RUN, DONE}.
- Adder usage: operands ACC and (Q[0] ? M : 0), Cin=0, add mode only. The subtract path is never selected.
- IDLE: if start=1, load M=a, Q=b, ACC=0, C=0, CNT=0 and go to RUN. Otherwise stay in IDLE.
- RUN, one iteration per cycle:
  - Compute {C,ACC} = ACC + (Q[0] ? M : 0).
  - Shift {C,ACC,Q} right by 1.
  - CNT += 1.
  - When CNT reaches 4, load product={ACC,Q} (post-shift) and go to DONE.
- DONE: done=1 for exactly one cycle, then unconditionally return to IDLE.
- start is ignored in RUN and DONE. No queueing: a request made while busy is lost.
- Arithmetic: result is exact. 15×15=225 fits in 8 bits, so there is no overflow condition. The adder carry is always captured into C.
- Operands a/b may change freely after the start cycle without affecting the result.

## Timing
- Reset values: busy=0, done=0, product=8'h00, state=IDLE, all internal registers 0.
- rst=1 at any edge, including mid-RUN or in DONE, forces the reset values on that edge. It overrides start. No done pulse is emitted for an aborted operation.
- Latency with the macro undefined:
  - start high in IDLE at cycle 0.
  - busy=1 in cycles 1..5.
  - RUN occupies cycles 1..4.
  - done=1 and product valid in cycle 5.
  - busy=0 in cycle 6.
- Earliest back-to-back: start high in cycle 6, the first IDLE cycle, is accepted.
- product changes only on the edge entering DONE, or on reset.

## Configuration
- Macro SEQ_MUL4_EARLY_EXIT_EN.
- Defined: after each RUN iteration k (k=1..4), if the unconsumed multiplier bits b>>k are all zero:
  - load product = ({C,ACC,Q} post-shift) >> (4−k), i.e. the final value;
  - go to DONE immediately.
- RUN length is then n = max(1, index of MSB of b + 1) cycles, and done occurs at cycle n+1.
- Undefined: fixed 4 RUN iterations, done always at cycle 5.
- Product value is identical in both builds.

## Test plan
- Reset, then a=15, b=15, start in cycle 0 → busy cycles 1..5, done pulse cycle 5 only, product=8'hE1 (225). With the macro defined, done is still at cycle 5 because the MSB of b is bit 3.
- a=9, b=6, start → product=8'h36 (54). Done at cycle 5 without the macro, cycle 4 with it.
- a=7, b=0 → product=8'h00. Done at cycle 5 without the macro, cycle 2 with it. a=0, b=11 → product=0, done at cycle 5 in both builds.
- a=3, b=5 started; start re-asserted in cycles 2..5 with a=15, b=15 → single done, product=8'h0F. A new start in cycle 6 is accepted and gives 8'hE1 at cycle 11.
- a=12, b=13 started; rst=1 in cycle 3 → busy=0, done=0, product=0 from cycle 4, and no done pulse follows. A start in cycle 5 after rst is released runs normally to 8'h9C (156).
- Exhaustive sweep of all 256 a/b pairs, one per operation → product == a*b and done-cycle == the latency formula for the build under test.
